pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator that converts mixed audio samples into 1-bit pulse streams. It is the next generation of the single-channel 8-bit PWM stage and adds configurable resolution, channel count and clock prescaler. Duty updates use a valid/ready handshake and take effect only at period boundaries, so no period is ever glitched. It sits between the sample mixer and the output pins.

---
 rtl/pwm_multi.sv | 135 +++++++++++++
 tb/tb_pwm_multi.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared prescaled counter, per-channel duty compare, and duty
// updates through a valid/ready shadow register applied only at period boundaries.
// Optional: define PWM_CENTER_ALIGN_EN to allow center-aligned counting selected by mode.
module pwm_multi #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CHANNELS   = 1,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                      clk,
    input  logic                      nRst,
    input  logic                      enable,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      duty_valid,
    output logic                      duty_ready,
    input  logic                      mode,
    output logic [CHANNELS-1:0]       pwm_o,
    output logic                      period_start
);

    logic [PRESCALE_W-1:0]     presc_cnt_q, presc_cnt_d;
    logic [WIDTH-1:0]          count_q, count_d;
    logic [CHANNELS*WIDTH-1:0] active_q, active_d;
    logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
    logic                      pending_q, pending_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      period_start_q, period_start_d;
    logic                      tick, boundary, accept;

`ifdef PWM_CENTER_ALIGN_EN
    localparam logic [WIDTH-1:0] CntMax = '1;
    logic dir_down_q, dir_down_d;
    logic mode_q, mode_d;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // Prescaler and counter; a boundary is the tick on which the counter returns to zero.
    always_comb begin
        tick        = (presc_cnt_q >= prescale);
        presc_cnt_d = tick ? '0 : presc_cnt_q + PRESCALE_W'(1);
        count_d     = count_q;
`ifdef PWM_CENTER_ALIGN_EN
        dir_down_d  = dir_down_q;
        if (tick) begin
            if (mode_q && dir_down_q) begin
                count_d = count_q - WIDTH'(1);
            end else if (mode_q && (count_q == CntMax)) begin
                count_d    = CntMax - WIDTH'(1);
                dir_down_d = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
        if (count_d == '0) begin
            dir_down_d = 1'b0;
        end
`else
        if (tick) begin
            count_d = count_q + WIDTH'(1);
        end
`endif
        boundary = tick && (count_d == '0);
        // While stopped every cycle counts as a boundary so a pending word lands at once.
        if (!enable) begin
            presc_cnt_d = '0;
            count_d     = '0;
            boundary    = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_d  = 1'b0;
`endif
        end
`ifdef PWM_CENTER_ALIGN_EN
        mode_d = boundary ? mode : mode_q;
`endif
    end

    // Accept and apply are exclusive: accept needs an empty shadow, apply needs a full one.
    always_comb begin
        accept    = duty_valid && !pending_q;
        shadow_d  = accept ? duty : shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (accept) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        pwm_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable && (count_q < active_q[i*WIDTH +: WIDTH]);
        end
        // The first clk of count zero is the only cycle with both counters at zero.
        period_start_d = enable && (count_q == '0) && (presc_cnt_q == '0);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            presc_cnt_q    <= '0;
            count_q        <= '0;
            active_q       <= '0;
            shadow_q       <= '0;
            pending_q      <= 1'b0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_q     <= 1'b0;
            mode_q         <= 1'b0;
`endif
        end else begin
            presc_cnt_q    <= presc_cnt_d;
            count_q        <= count_d;
            active_q       <= active_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_q     <= dir_down_d;
            mode_q         <= mode_d;
`endif
        end
    end

    assign duty_ready   = !pending_q;
    assign pwm_o        = pwm_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: measures whole periods and compares period length and
// per-channel high time against arithmetic expectations derived from duty and prescale.
module tb_pwm_multi;

    localparam int W    = 8;
    localparam int CH   = 2;
    localparam int PW   = 8;
    localparam int NPER = 1 << W;

    logic           clk = 1'b0;
    logic           nRst = 1'b0;
    logic           enable = 1'b0;
    logic [PW-1:0]  prescale = '0;
    logic [CH*W-1:0] duty = '0;
    logic           duty_valid = 1'b0;
    logic           duty_ready;
    logic           mode = 1'b0;
    logic [CH-1:0]  pwm_o;
    logic           period_start;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pwm_multi #(
        .WIDTH(W),
        .CHANNELS(CH),
        .PRESCALE_W(PW)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .enable(enable),
        .prescale(prescale),
        .duty(duty),
        .duty_valid(duty_valid),
        .duty_ready(duty_ready),
        .mode(mode),
        .pwm_o(pwm_o),
        .period_start(period_start)
    );

    // Reference: a period is 2^W ticks (edge) or 2*(2^W-1) ticks (center), each tick presc+1 clk.
    function automatic int exp_len(input int presc, input bit center);
        return (center ? 2 * (NPER - 1) : NPER) * (presc + 1);
    endfunction

    function automatic int exp_high(input int d, input int presc, input bit center);
        if (center) return ((d == 0) ? 0 : 2 * d - 1) * (presc + 1);
        return d * (presc + 1);
    endfunction

    task automatic wait_start(input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (period_start === 1'b1) ok = 1'b1;
        end
    endtask

    // Called on a negedge where period_start is seen; returns on the next such negedge.
    task automatic measure(input int budget, output int len, output int hi0, output int hi1,
                           output int head0, output int tail0, output logic [CH-1:0] first);
        bit in_head = 1'b1;
        len = 0; hi0 = 0; hi1 = 0; head0 = 0; tail0 = 0;
        first = pwm_o;
        do begin
            len++;
            if (pwm_o[0] === 1'b1) begin
                hi0++;
                tail0++;
                if (in_head) head0++;
            end else begin
                in_head = 1'b0;
                tail0   = 0;
            end
            if (pwm_o[1] === 1'b1) hi1++;
            @(negedge clk);
        end while (period_start !== 1'b1 && len < budget);
    endtask

    task automatic write_duty(input int d0, input int d1, output bit ok);
        int n = 0;
        while (duty_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        ok = (duty_ready === 1'b1);
        duty       = {W'(d1), W'(d0)};
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
    endtask

    // Write a duty pair, skip to the period it governs, and measure that period.
    task automatic setup_case(input int d0, input int d1, input int presc, output bit ok,
                              output int len, output int hi0, output int hi1, output int head0,
                              output int tail0, output logic [CH-1:0] first);
        bit ok1, ok2, ok3;
        prescale = PW'(presc);
        wait_start(6000, ok1);
        write_duty(d0, d1, ok2);
        wait_start(6000, ok3);
        ok = ok1 && ok2 && ok3;
        measure(6000, len, hi0, hi1, head0, tail0, first);
    endtask

    task automatic test_reset;
        nRst = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (pwm_o !== '0) begin
            n_fail++; $display("FAIL reset_pwm: got %b want 00", pwm_o);
        end
        n_tests++;
        if (period_start !== 1'b0) begin
            n_fail++; $display("FAIL reset_period_start: got %b want 0", period_start);
        end
        n_tests++;
        if (duty_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_duty_ready: got %b want 1", duty_ready);
        end
        nRst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        int len, hi0, hi1, h, t;
        logic [CH-1:0] f;
        prescale = '0;
        write_duty(64, 0, ok);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        n_tests++;
        if (!ok || period_start !== 1'b1) begin
            n_fail++; $display("FAIL basic_start_on_enable: got %b want 1", period_start);
        end
        n_tests++;
        if (pwm_o !== 2'b01) begin
            n_fail++; $display("FAIL basic_first_pwm: got %b want 01", pwm_o);
        end
        measure(6000, len, hi0, hi1, h, t, f);
        n_tests++;
        if (len !== exp_len(0, 0) || hi0 !== exp_high(64, 0, 0) || hi1 !== 0) begin
            n_fail++;
            $display("FAIL basic_period: got len=%0d hi0=%0d hi1=%0d want len=%0d hi0=%0d hi1=0",
                     len, hi0, hi1, exp_len(0, 0), exp_high(64, 0, 0));
        end
        measure(6000, len, hi0, hi1, h, t, f);
        n_tests++;
        if (len !== exp_len(0, 0)) begin
            n_fail++; $display("FAIL basic_repeat_len: got %0d want %0d", len, exp_len(0, 0));
        end
    endtask

    task automatic test_update_mid_period;
        int hi = 0;
        int len, hi0, hi1, h, t;
        logic [CH-1:0] f;
        for (int i = 0; i < NPER; i++) begin
            if (pwm_o[0] === 1'b1) hi++;
            if (i == 100) begin
                duty = {W'(0), W'(200)};
                duty_valid = 1'b1;
            end
            if (i == 101) begin
                n_tests++;
                if (duty_ready !== 1'b0) begin
                    n_fail++; $display("FAIL upd_ready_low: got %b want 0", duty_ready);
                end
                duty = {W'(0), W'(17)};
            end
            if (i == 102) duty_valid = 1'b0;
            if (i == 254) begin
                n_tests++;
                if (duty_ready !== 1'b0) begin
                    n_fail++; $display("FAIL upd_ready_pre_boundary: got %b want 0", duty_ready);
                end
            end
            if (i == 255) begin
                n_tests++;
                if (duty_ready !== 1'b1) begin
                    n_fail++; $display("FAIL upd_ready_post_boundary: got %b want 1", duty_ready);
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (period_start !== 1'b1 || hi !== 64) begin
            n_fail++;
            $display("FAIL upd_old_period: got start=%b hi=%0d want start=1 hi=64",
                     period_start, hi);
        end
        measure(6000, len, hi0, hi1, h, t, f);
        n_tests++;
        if (len !== exp_len(0, 0) || hi0 !== exp_high(200, 0, 0)) begin
            n_fail++;
            $display("FAIL upd_new_period: got len=%0d hi0=%0d want len=%0d hi0=%0d",
                     len, hi0, exp_len(0, 0), exp_high(200, 0, 0));
        end
    endtask

    task automatic test_back_to_back;
        int len, hi0, hi1, h, t;
        logic [CH-1:0] f;
        for (int i = 0; i < NPER; i++) begin
            if (i == 254) begin
                duty = {W'(0), W'(50)};
                duty_valid = 1'b1;
            end
            if (i == 255) begin
                duty_valid = 1'b0;
                n_tests++;
                if (duty_ready !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_ready: got %b want 0", duty_ready);
                end
            end
            @(negedge clk);
        end
        measure(6000, len, hi0, hi1, h, t, f);
        n_tests++;
        if (hi0 !== exp_high(200, 0, 0)) begin
            n_fail++; $display("FAIL b2b_deferred: got hi0=%0d want %0d", hi0, exp_high(200, 0, 0));
        end
        measure(6000, len, hi0, hi1, h, t, f);
        n_tests++;
        if (hi0 !== exp_high(50, 0, 0)) begin
            n_fail++; $display("FAIL b2b_applied: got hi0=%0d want %0d", hi0, exp_high(50, 0, 0));
        end
    endtask

    task automatic test_prescale;
        bit ok;
        int len, hi0, hi1, h, t;
        logic [CH-1:0] f;
        int dl[3] = '{10, 0, 255};
        for (int k = 0; k < 3; k++) begin
            setup_case(dl[k], 0, 3, ok, len, hi0, hi1, h, t, f);
            n_tests++;
            if (!ok || len !== exp_len(3, 0) || hi0 !== exp_high(dl[k], 3, 0)) begin
                n_fail++;
                $display("FAIL presc_duty%0d: got ok=%b len=%0d hi0=%0d want len=%0d hi0=%0d",
                         dl[k], ok, len, hi0, exp_len(3, 0), exp_high(dl[k], 3, 0));
            end
        end
    endtask

    task automatic test_two_channels;
        bit ok;
        int len, hi0, hi1, h, t;
        logic [CH-1:0] f;
        setup_case(32, 192, 0, ok, len, hi0, hi1, h, t, f);
        n_tests++;
        if (!ok || hi0 !== exp_high(32, 0, 0) || hi1 !== exp_high(192, 0, 0)) begin
            n_fail++;
            $display("FAIL two_ch_high: got ok=%b hi0=%0d hi1=%0d want hi0=%0d hi1=%0d",
                     ok, hi0, hi1, exp_high(32, 0, 0), exp_high(192, 0, 0));
        end
        n_tests++;
        if (f !== 2'b11) begin
            n_fail++; $display("FAIL two_ch_rise_together: got %b want 11", f);
        end
    endtask

    task automatic test_random;
        bit ok;
        int len, hi0, hi1, h, t, d0, d1, p;
        logic [CH-1:0] f;
        for (int k = 0; k < 4; k++) begin
            d0 = $urandom_range(0, NPER - 1);
            d1 = $urandom_range(0, NPER - 1);
            p  = $urandom_range(0, 2);
            setup_case(d0, d1, p, ok, len, hi0, hi1, h, t, f);
            n_tests++;
            if (!ok || len !== exp_len(p, 0) || hi0 !== exp_high(d0, p, 0) ||
                hi1 !== exp_high(d1, p, 0)) begin
                n_fail++;
                $display("FAIL rand_%0d: d=%0d/%0d p=%0d got ok=%b len=%0d hi=%0d/%0d want %0d %0d/%0d",
                         k, d0, d1, p, ok, len, hi0, hi1, exp_len(p, 0), exp_high(d0, p, 0),
                         exp_high(d1, p, 0));
            end
        end
    endtask

    task automatic test_enable;
        int len, hi0, hi1, h, t;
        logic [CH-1:0] f;
        prescale = '0;
        repeat (40) @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (pwm_o !== '0 || period_start !== 1'b0) begin
            n_fail++;
            $display("FAIL en_off_outputs: got pwm=%b start=%b want 00 0", pwm_o, period_start);
        end
        duty = {W'(3), W'(77)};
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        n_tests++;
        if (duty_ready !== 1'b0) begin
            n_fail++; $display("FAIL en_off_accept: got ready=%b want 0", duty_ready);
        end
        @(negedge clk);
        n_tests++;
        if (duty_ready !== 1'b1) begin
            n_fail++; $display("FAIL en_off_apply: got ready=%b want 1", duty_ready);
        end
        enable = 1'b1;
        @(negedge clk);
        n_tests++;
        if (period_start !== 1'b1 || pwm_o !== 2'b11) begin
            n_fail++;
            $display("FAIL en_restart: got start=%b pwm=%b want 1 11", period_start, pwm_o);
        end
        measure(6000, len, hi0, hi1, h, t, f);
        n_tests++;
        if (len !== exp_len(0, 0) || hi0 !== exp_high(77, 0, 0) || hi1 !== exp_high(3, 0, 0)) begin
            n_fail++;
            $display("FAIL en_period: got len=%0d hi=%0d/%0d want %0d %0d/%0d", len, hi0, hi1,
                     exp_len(0, 0), exp_high(77, 0, 0), exp_high(3, 0, 0));
        end
    endtask

`ifdef PWM_CENTER_ALIGN_EN
    task automatic test_center;
        bit ok;
        int len, hi0, hi1, head, tail;
        logic [CH-1:0] f;
        mode = 1'b1;
        setup_case(100, 100, 0, ok, len, hi0, hi1, head, tail, f);
        n_tests++;
        if (!ok || len !== exp_len(0, 1) || hi0 !== exp_high(100, 0, 1)) begin
            n_fail++;
            $display("FAIL center_period: got ok=%b len=%0d hi0=%0d want len=%0d hi0=%0d",
                     ok, len, hi0, exp_len(0, 1), exp_high(100, 0, 1));
        end
        n_tests++;
        if (head !== 100 || tail !== 99) begin
            n_fail++;
            $display("FAIL center_runs: got head=%0d tail=%0d want 100 99", head, tail);
        end
        mode = 1'b0;
        wait_start(6000, ok);
    endtask
`else
    task automatic test_mode_ignored;
        bit ok;
        int len, hi0, hi1, h, t;
        logic [CH-1:0] f;
        mode = 1'b1;
        setup_case(100, 100, 0, ok, len, hi0, hi1, h, t, f);
        n_tests++;
        if (!ok || len !== exp_len(0, 0) || hi0 !== exp_high(100, 0, 0)) begin
            n_fail++;
            $display("FAIL mode_ignored: got ok=%b len=%0d hi0=%0d want len=%0d hi0=%0d",
                     ok, len, hi0, exp_len(0, 0), exp_high(100, 0, 0));
        end
        mode = 1'b0;
    endtask
`endif

    task automatic test_reset_mid;
        bit ok;
        int len, hi0, hi1, h, t;
        int seen = 0;
        logic [CH-1:0] f;
        setup_case(128, 128, 0, ok, len, hi0, hi1, h, t, f);
        repeat (50) @(negedge clk);
        duty = {W'(9), W'(9)};
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        repeat (9) @(negedge clk);
        n_tests++;
        if (!ok || duty_ready !== 1'b0 || pwm_o !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got ok=%b ready=%b pwm=%b want 1 0 11",
                     ok, duty_ready, pwm_o);
        end
        nRst = 1'b0;
        #1;
        n_tests++;
        if (pwm_o !== '0 || period_start !== 1'b0 || duty_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_async: got pwm=%b start=%b ready=%b want 00 0 1",
                     pwm_o, period_start, duty_ready);
        end
        @(negedge clk);
        nRst = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (pwm_o !== '0) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL rst_mid_low_after: got %0d high clk want 0", seen);
        end
        setup_case(40, 0, 0, ok, len, hi0, hi1, h, t, f);
        n_tests++;
        if (!ok || hi0 !== exp_high(40, 0, 0) || hi1 !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_rewrite: got ok=%b hi=%0d/%0d want %0d/0",
                     ok, hi0, hi1, exp_high(40, 0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_update_mid_period();
        test_back_to_back();
        test_prescale();
        test_two_channels();
        test_random();
        test_enable();
`ifdef PWM_CENTER_ALIGN_EN
        test_center();
`else
        test_mode_ignored();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
